// File: rtl/wb_unit.sv
// rtl/wb_unit.sv - write-back stage: result select, load extraction, rf write, commit handoff
// One instruction at a time: IDLE -> (WAIT_MEM) -> WRITE -> COMMIT -> IDLE.
module wb_unit #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              exu_valid,
   output logic              exu_ready,
   input  logic [XLEN-1:0]   exu_result,
   input  logic [XLEN-1:0]   exu_csr,
   input  logic [XLEN-1:0]   exu_pc,
   input  logic [XLEN-1:0]   exu_dnpc,
   input  logic [REG_AW-1:0] exu_rd,
   input  logic              exu_rd_wen,
   input  logic [1:0]        exu_wb_sel,
   input  logic [2:0]        exu_funct3,
   input  logic              lsu_rvalid,
   output logic              lsu_rready,
   input  logic [XLEN-1:0]   lsu_rdata,
   output logic              rf_wen,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [XLEN-1:0]   rf_wdata,
   output logic              commit_valid,
   input  logic              commit_ready,
   output logic [XLEN-1:0]   commit_pc,
   output logic [XLEN-1:0]   commit_dnpc,
   output logic              wb_err
);

   typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE, COMMIT} state_t;

   localparam logic [1:0] SEL_ALU  = 2'd0;
   localparam logic [1:0] SEL_LOAD = 2'd1;
   localparam logic [1:0] SEL_PC4  = 2'd2;

   state_t state, state_nx;

   logic [XLEN-1:0]   result_q, csr_q, pc_q, dnpc_q, load_q;
   logic [REG_AW-1:0] rd_q;
   logic              rd_wen_q, err_q;
   logic [1:0]        sel_q;
   logic [2:0]        funct3_q;

   logic              acc_err;
   logic [7:0]        byte_lane;
   logic [15:0]       half_lane;
   logic [XLEN-1:0]   load_val, sel_val;

   // Alignment/encoding faults are known at accept time, so they are latched with the instruction.
   always_comb begin
      acc_err = 1'b0;
      case (exu_funct3)
         3'b000, 3'b100: acc_err = 1'b0;
         3'b001, 3'b101: acc_err = exu_result[0];
         3'b010:         acc_err = |exu_result[1:0];
         default:        acc_err = 1'b1;
      endcase
      if (exu_wb_sel != SEL_LOAD) acc_err = 1'b0;
   end

   always_comb begin
      byte_lane = lsu_rdata[{result_q[1:0], 3'b000} +: 8];
      half_lane = lsu_rdata[{result_q[1], 4'b0000} +: 16];
      case (funct3_q)
         3'b000:  load_val = {{(XLEN-8){byte_lane[7]}}, byte_lane};
         3'b001:  load_val = {{(XLEN-16){half_lane[15]}}, half_lane};
         3'b100:  load_val = {{(XLEN-8){1'b0}}, byte_lane};
         3'b101:  load_val = {{(XLEN-16){1'b0}}, half_lane};
         default: load_val = lsu_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     if (exu_valid) state_nx = (exu_wb_sel == SEL_LOAD) ? WAIT_MEM : WRITE;
         WAIT_MEM: if (lsu_rvalid) state_nx = WRITE;
         WRITE:    state_nx = COMMIT;
         COMMIT:   if (commit_ready) state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         csr_q    <= '0;
         pc_q     <= '0;
         dnpc_q   <= '0;
         load_q   <= '0;
         rd_q     <= '0;
         rd_wen_q <= 1'b0;
         err_q    <= 1'b0;
         sel_q    <= '0;
         funct3_q <= '0;
      end else begin
         if (state == IDLE && exu_valid) begin
            result_q <= exu_result;
            csr_q    <= exu_csr;
            pc_q     <= exu_pc;
            dnpc_q   <= exu_dnpc;
            rd_q     <= exu_rd;
            rd_wen_q <= exu_rd_wen;
            err_q    <= acc_err;
            sel_q    <= exu_wb_sel;
            funct3_q <= exu_funct3;
         end
         if (state == WAIT_MEM && lsu_rvalid) load_q <= load_val;
      end
   end

   always_comb begin
      case (sel_q)
         SEL_ALU:  sel_val = result_q;
         SEL_LOAD: sel_val = load_q;
         SEL_PC4:  sel_val = pc_q + XLEN'(4);
         default:  sel_val = csr_q;
      endcase
   end

   // Outputs are gated by the registered state so nothing leaks outside its phase.
   always_comb begin
      exu_ready    = (state == IDLE);
      lsu_rready   = (state == WAIT_MEM);
      rf_wen       = (state == WRITE) && rd_wen_q && (rd_q != '0) && !err_q;
      rf_waddr     = (state == WRITE) ? rd_q : '0;
      rf_wdata     = (state == WRITE) ? sel_val : '0;
      wb_err       = (state == WRITE) && err_q;
      commit_valid = (state == COMMIT);
      commit_pc    = (state == COMMIT) ? pc_q : '0;
      commit_dnpc  = (state == COMMIT) ? dnpc_q : '0;
   end

endmodule
